// File: rtl/irq_cause_arbiter_pkg.sv
// Shared types and elaboration-time parameter checks for the interrupt cause arbiter.
package irq_cause_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SERVICE = 2'd2
    } arb_state_e;

    // The highest cause code (base + last source) must fit in the cause field.
    function automatic bit cause_fits(input int base_cause, input int n_src, input int cause_w);
        longint top_code;
        longint limit;
        top_code = longint'(base_cause) + longint'(n_src) - 64'sd1;
        limit    = longint'(1) << cause_w;
        return top_code < limit;
    endfunction

    function automatic bit n_src_ok(input int n_src);
        return (n_src >= 1) && (n_src <= 32);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins; purely combinational.
// Zero latency; no backpressure.
module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan high to low so the last hit, the lowest index, is what remains.
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/irq_cause_arbiter.sv
// Interrupt cause arbiter: sync, pend, pick lowest-index enabled source, present its cause.
// Latency: 3 edges from io_irq to io_irq_valid; presentation holds until io_irq_ready.
module irq_cause_arbiter
    import irq_cause_arbiter_pkg::*;
#(
    parameter int               N_SRC      = 8,
    parameter int               CAUSE_W    = 5,
    parameter int               BASE_CAUSE = 2,
    parameter logic [N_SRC-1:0] EDGE_MASK  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   io_irq,
    input  logic [N_SRC-1:0]   io_irq_en,
    output logic [CAUSE_W:0]   io_irq_cause,
    output logic               io_irq_valid,
    input  logic               io_irq_ready,
    input  logic               io_done,
    output logic [N_SRC-1:0]   io_pending,
    output logic               io_busy
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    generate
        if (!n_src_ok(N_SRC) || !cause_fits(BASE_CAUSE, N_SRC, CAUSE_W)) begin : g_param_check
            $error("irq_cause_arbiter: N_SRC out of 1..32 or BASE_CAUSE+N_SRC-1 does not fit CAUSE_W");
        end
    endgenerate

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] irq_prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] claim_clr;
    logic [N_SRC-1:0] cand;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             claim;
    logic [CAUSE_W-1:0] code;
    arb_state_e       state;
    arb_state_e       state_nxt;

    assign rise      = irq_q & ~irq_prev;
    assign claim     = (state == ST_PRESENT) && io_irq_ready;
    assign claim_clr = claim ? (N_SRC'(1) << idx_q) : '0;

    // Edge sources: a new rise beats a same-cycle claim so no event is lost.
    assign pending_nxt = (EDGE_MASK & ((pending & ~claim_clr) | rise))
                       | (~EDGE_MASK & irq_q);

    assign cand = pending & io_irq_en;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req (cand),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    state_nxt = ST_PRESENT;
                    idx_nxt   = win_idx;
                end
            end
            ST_PRESENT: begin
                if (io_irq_ready) begin
                    state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (io_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q    <= '0;
            irq_prev <= '0;
            pending  <= '0;
            idx_q    <= '0;
            state    <= ST_IDLE;
        end else begin
            irq_q    <= io_irq;
            irq_prev <= irq_q;
            pending  <= pending_nxt;
            idx_q    <= idx_nxt;
            state    <= state_nxt;
        end
    end

    assign code         = CAUSE_W'(BASE_CAUSE) + CAUSE_W'(idx_q);
    assign io_irq_valid = (state == ST_PRESENT);
    assign io_irq_cause = io_irq_valid ? {1'b1, code} : '0;
    assign io_busy      = (state != ST_IDLE);
    assign io_pending   = pending;

endmodule

// File: tb/tb_irq_cause_arbiter.sv
module tb_irq_cause_arbiter;

    localparam logic [7:0] EDGE = 8'h46;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irq = '0;
    logic [7:0]  en = 8'hff;
    logic        ready = 1'b0;
    logic        done = 1'b0;
    logic [5:0]  cause;
    logic        valid;
    logic [7:0]  pending;
    logic        busy;

    logic [31:0] irq2 = '0;
    logic [31:0] en2 = '1;
    logic        ready2 = 1'b0;
    logic        done2 = 1'b0;
    logic [6:0]  cause2;
    logic        valid2;
    logic [31:0] pending2;
    logic        busy2;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state: plain integers per source.
    int m_q[8];
    int m_prev[8];
    int m_pend[8];
    int m_mode;   // 0 idle, 1 presenting, 2 servicing
    int m_idx;

    always #5 clk = ~clk;

    irq_cause_arbiter #(
        .N_SRC(8), .CAUSE_W(5), .BASE_CAUSE(2), .EDGE_MASK(EDGE)
    ) dut (
        .clk(clk), .reset(reset), .io_irq(irq), .io_irq_en(en),
        .io_irq_cause(cause), .io_irq_valid(valid), .io_irq_ready(ready),
        .io_done(done), .io_pending(pending), .io_busy(busy)
    );

    irq_cause_arbiter #(
        .N_SRC(32), .CAUSE_W(6), .BASE_CAUSE(2), .EDGE_MASK(32'h0)
    ) dut_wide (
        .clk(clk), .reset(reset), .io_irq(irq2), .io_irq_en(en2),
        .io_irq_cause(cause2), .io_irq_valid(valid2), .io_irq_ready(ready2),
        .io_done(done2), .io_pending(pending2), .io_busy(busy2)
    );

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_q[i] = 0; m_prev[i] = 0; m_pend[i] = 0;
        end
        m_mode = 0;
        m_idx  = 0;
    endtask

    task automatic model_step();
        int np[8];
        int nmode;
        int nidx;
        bit claimed;
        claimed = (m_mode == 1) && ready;
        for (int i = 0; i < 8; i++) begin
            if (EDGE[i])
                np[i] = ((m_pend[i] != 0 && !(claimed && m_idx == i)) ||
                         (m_q[i] != 0 && m_prev[i] == 0)) ? 1 : 0;
            else
                np[i] = m_q[i];
        end
        nmode = m_mode;
        nidx  = m_idx;
        if (m_mode == 0) begin
            for (int i = 7; i >= 0; i--)
                if (m_pend[i] != 0 && en[i]) begin nmode = 1; nidx = i; end
        end else if (m_mode == 1) begin
            if (ready) nmode = 2;
        end else if (done) begin
            nmode = 0;
        end
        for (int i = 0; i < 8; i++) begin
            m_prev[i] = m_q[i];
            m_q[i]    = irq[i] ? 1 : 0;
            m_pend[i] = np[i];
        end
        m_mode = nmode;
        m_idx  = nidx;
    endtask

    function automatic logic [7:0] exp_pending();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = (m_pend[i] != 0);
        return p;
    endfunction

    function automatic logic [5:0] exp_cause();
        return (m_mode == 1) ? 6'(32 + 2 + m_idx) : 6'h00;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq = '0; en = 8'hff; ready = 1'b0; done = 1'b0;
        irq2 = '0; ready2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_chk++;
        if ({valid, cause, pending, busy} !== 16'h0)
            $display("FAIL reset_outputs got valid=%b cause=%h pend=%h busy=%b want all 0", valid, cause, pending, busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(); cycle();
        n_chk++;
        if (valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_idle got valid=%b busy=%b want 0 0", valid, busy);
        else n_pass++;
    endtask

    task automatic test_level();
        do_reset();
        irq = 8'h08; ready = 1'b1;
        cycle(); cycle();
        n_chk++;
        if (valid !== 1'b0) $display("FAIL level_early got valid=%b want 0", valid);
        else n_pass++;
        cycle();
        n_chk++;
        if (valid !== 1'b1 || cause !== 6'h25)
            $display("FAIL level_present got valid=%b cause=%h want 1 25", valid, cause);
        else n_pass++;
        cycle();
        n_chk++;
        if (busy !== 1'b1 || valid !== 1'b0 || pending[3] !== 1'b1)
            $display("FAIL level_service got busy=%b valid=%b pend=%h want 1 0 pend[3]=1", busy, valid, pending);
        else n_pass++;
        done = 1'b1;
        cycle();
        done = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL level_done got busy=%b valid=%b want 0 0", busy, valid);
        else n_pass++;
        cycle();
        n_chk++;
        if (valid !== 1'b1 || cause !== 6'h25)
            $display("FAIL back_to_back got valid=%b cause=%h want 1 25", valid, cause);
        else n_pass++;
    endtask

    task automatic test_edge_pair();
        do_reset();
        irq = 8'h42;
        repeat (3) cycle();
        n_chk++;
        if (cause !== 6'h23 || pending !== 8'h42)
            $display("FAIL edge_first got cause=%h pend=%h want 23 42", cause, pending);
        else n_pass++;
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        n_chk++;
        if (pending !== 8'h40 || busy !== 1'b1)
            $display("FAIL edge_claim1 got pend=%h busy=%b want 40 1", pending, busy);
        else n_pass++;
        done = 1'b1; cycle(); done = 1'b0;
        cycle();
        n_chk++;
        if (valid !== 1'b1 || cause !== 6'h28)
            $display("FAIL edge_second got valid=%b cause=%h want 1 28", valid, cause);
        else n_pass++;
        ready = 1'b1; cycle(); ready = 1'b0;
        done = 1'b1; cycle(); done = 1'b0;
        n_chk++;
        if (pending !== 8'h00 || busy !== 1'b0)
            $display("FAIL edge_clear got pend=%h busy=%b want 00 0", pending, busy);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        irq = 8'h10;
        repeat (3) cycle();
        irq = 8'h11;
        for (int k = 0; k < 10; k++) begin
            en   = (k >= 3 && k < 7) ? 8'h00 : 8'hff;
            done = (k == 5);
            cycle();
            n_chk++;
            if (valid !== 1'b1 || cause !== 6'h26)
                $display("FAIL hold_cycle%0d got valid=%b cause=%h want 1 26", k, valid, cause);
            else n_pass++;
        end
        en = 8'hff; done = 1'b0;
        ready = 1'b1; cycle(); ready = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || valid !== 1'b0)
            $display("FAIL hold_claim got busy=%b valid=%b want 1 0", busy, valid);
        else n_pass++;
        done = 1'b1; cycle(); done = 1'b0;
        cycle();
        n_chk++;
        if (valid !== 1'b1 || cause !== 6'h22)
            $display("FAIL hold_next got valid=%b cause=%h want 1 22", valid, cause);
        else n_pass++;
    endtask

    task automatic test_rearm();
        do_reset();
        irq = 8'h04; ready = 1'b1;
        repeat (4) cycle();
        ready = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || pending !== 8'h00)
            $display("FAIL rearm_service got busy=%b pend=%h want 1 00", busy, pending);
        else n_pass++;
        irq = 8'h00; cycle();
        irq = 8'h04; cycle(); cycle();
        n_chk++;
        if (pending !== 8'h04 || valid !== 1'b0)
            $display("FAIL rearm_pend got pend=%h valid=%b want 04 0", pending, valid);
        else n_pass++;
        done = 1'b1; cycle(); done = 1'b0;
        cycle();
        n_chk++;
        if (valid !== 1'b1 || cause !== 6'h24)
            $display("FAIL rearm_present got valid=%b cause=%h want 1 24", valid, cause);
        else n_pass++;
        // New rise lands on the same edge as the claim.
        irq = 8'h00; cycle();
        irq = 8'h04; cycle();
        ready = 1'b1; cycle(); ready = 1'b0;
        n_chk++;
        if (pending !== 8'h04 || busy !== 1'b1)
            $display("FAIL set_wins got pend=%h busy=%b want 04 1", pending, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        irq = 8'h08; ready = 1'b1;
        repeat (4) cycle();
        n_chk++;
        if (busy !== 1'b1) $display("FAIL mid_busy got busy=%b want 1", busy);
        else n_pass++;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({valid, cause, pending, busy} !== 16'h0)
            $display("FAIL mid_reset got valid=%b cause=%h pend=%h busy=%b want all 0", valid, cause, pending, busy);
        else n_pass++;
        irq = 8'h00; ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_chk++;
            if (valid !== 1'b0) $display("FAIL mid_after%0d got valid=%b want 0", k, valid);
            else n_pass++;
        end
    endtask

    task automatic test_wide();
        do_reset();
        irq2 = 32'h8000_0000;
        repeat (3) cycle();
        n_chk++;
        if (valid2 !== 1'b1 || cause2 !== 7'h61 || pending2 !== 32'h8000_0000)
            $display("FAIL wide_src31 got valid=%b cause=%h pend=%h want 1 61 80000000", valid2, cause2, pending2);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(7) == 0) irq[i] = ~irq[i];
            if ((c % 60) == 0) en = 8'($urandom | $urandom);
            ready = ($urandom_range(3) != 0);
            done  = ($urandom_range(2) == 0);
            cycle();
            n_chk++;
            if (valid !== (m_mode == 1) || cause !== exp_cause())
                $display("FAIL rand_cause c=%0d got valid=%b cause=%h want %b %h", c, valid, cause, m_mode == 1, exp_cause());
            else n_pass++;
            n_chk++;
            if (pending !== exp_pending() || busy !== (m_mode != 0))
                $display("FAIL rand_state c=%0d got pend=%h busy=%b want %h %b", c, pending, busy, exp_pending(), m_mode != 0);
            else n_pass++;
        end
        ready = 1'b0; done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_pair();
        test_hold();
        test_rearm();
        test_reset_mid();
        test_wide();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_cause_arbiter.md
IRQ_CAUSE_ARBITER -- requirements
Module: irq_cause_arbiter

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt sources, range 1..32.
REQ-002 Parameter CAUSE_W, default 5: cause-code width, excluding the interrupt flag bit.
REQ-003 Parameter BASE_CAUSE, default 2: cause code of source 0; source i reports BASE_CAUSE+i.
REQ-004 Parameter EDGE_MASK, default 0 (N_SRC bits): bit i=1 makes source i rising-edge latched; bit i=0 makes it level-sensitive.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 io_irq  in  N_SRC  raw interrupt request lines.
REQ-008 io_irq_en  in  N_SRC  per-source enable mask.
REQ-009 io_irq_cause  out  CAUSE_W+1  {1'b1, code} while valid; all-zero otherwise.
REQ-010 io_irq_valid  out  1  a cause is being presented.
REQ-011 io_irq_ready  in  1  consumer claims the presented cause.
REQ-012 io_done  in  1  one-cycle pulse: service of the claimed source is complete.
REQ-013 io_pending  out  N_SRC  current pending register, for debug.
REQ-014 io_busy  out  1  high in the PRESENT and SERVICE states.

Function
REQ-015 io_irq SHALL be registered once (irq_q) before use; edge detection SHALL use irq_q and the previous irq_q.
REQ-016 An edge source SHALL set its pending bit on a 0->1 transition of irq_q; the bit stays set until that source is claimed.
REQ-017 For a level source, the pending bit SHALL equal irq_q.
REQ-018 Candidates SHALL be pending & io_irq_en; the winner SHALL be the lowest-index candidate (fixed priority).
REQ-019 FSM states SHALL be IDLE, PRESENT and SERVICE; reset state is IDLE.
REQ-020 IDLE->PRESENT when at least one candidate exists; the winner index SHALL be latched in the same edge.
REQ-021 In PRESENT, io_irq_valid=1 and io_irq_cause={1'b1, BASE_CAUSE+idx}, CAUSE_W bits wide; the value SHALL stay stable until claimed, even if higher-priority sources arrive.
REQ-022 PRESENT->SERVICE on io_irq_valid & io_irq_ready; for an edge source, the latched source's pending bit SHALL clear on that same edge.
REQ-023 SERVICE->IDLE on io_done; io_done SHALL be ignored in IDLE and PRESENT.
REQ-024 Latency: io_irq rising at edge k SHALL give io_irq_valid=1 after edge k+3 (sync, pending, latch); a back-to-back re-present SHALL take 1 cycle after leaving SERVICE.
REQ-025 If the latched source's enable drops during PRESENT, the presentation SHALL still complete (no retraction).
REQ-026 An edge re-arriving on a source that is in SERVICE SHALL set its pending bit again and not be lost.
REQ-027 A simultaneous new edge and claim on the same edge source SHALL leave the bit set (set wins).
REQ-028 Elaboration SHALL fail if BASE_CAUSE+N_SRC-1 >= 2^CAUSE_W or N_SRC is out of range.

Reset
REQ-029 Asserting reset (any time, including mid-handshake) SHALL immediately clear irq_q, the edge history, pending, the latched index and the FSM (to IDLE); all outputs SHALL go to 0.
REQ-030 Release of reset SHALL be synchronised externally; the block SHALL take no action until the first rising edge after release.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and a cause-code width check function.
REQ-032 Priority selection SHALL be one sub-module, irq_prio_enc (N_SRC-wide request in; index and any-valid out; purely combinational).

Verification
REQ-033 Defaults, irq[3] level high, en=all, ready=1 -> valid at cycle 3, cause=6'h25, pending[3] still set after claim.
REQ-034 irq[1] and irq[6] edge (EDGE_MASK=8'h42) in the same cycle -> cause 6'h23 first, then after done, 6'h28; both pending bits clear.
REQ-035 Hold ready=0 for 10 cycles while irq[0] rises during PRESENT on source 4 -> cause stays 6'h26 throughout.
REQ-036 Edge on source 2 during SERVICE of source 2 -> after done, source 2 is re-presented (cause 6'h24).
REQ-037 Assert reset in SERVICE -> outputs 0 asynchronously; after release with irq idle, valid stays 0.
REQ-038 Parameters N_SRC=32, CAUSE_W=5, BASE_CAUSE=2 -> elaboration error; with CAUSE_W=6, source 31 gives cause 7'h61.
